// File: rtl/vx_lane_responder.sv
// vx_lane_responder: multi-lane memory responder with credit-based flow control.
// Accepts a batch of lane requests per cycle into a byte-enabled backing store,
// carries read responses through a fixed-latency pipeline into a response queue,
// and presents the queue head on registered outputs.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req_valid_in        - per-lane request valid
//   req_rw_in           - per-lane 1=write, 0=read
//   req_byteen_in       - per-lane write byte enables
//   req_addr_in         - per-lane word address
//   req_data_in         - per-lane write data
//   req_tag_in          - per-lane request tag
//   req_ready_in        - per-lane accept (all lanes identical)
//   rsp_valid_out       - response valid
//   rsp_tmask_out       - lanes carrying read data
//   rsp_data_out        - per-lane read data (zero outside tmask)
//   rsp_tag_out         - response tag
//   rsp_ready_out       - downstream accepts response
module vx_lane_responder #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DATA_SIZE = 4,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned NUM_WORDS = 64,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RSP_QUEUE = 4,
    localparam int unsigned DATA_WIDTH = 8 * DATA_SIZE,
    localparam int unsigned ADDR_WIDTH = 32 - $clog2(DATA_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [LANES-1:0]                     req_valid_in,
    input  logic [LANES-1:0]                     req_rw_in,
    input  logic [LANES-1:0][DATA_SIZE-1:0]      req_byteen_in,
    input  logic [LANES-1:0][ADDR_WIDTH-1:0]     req_addr_in,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]     req_data_in,
    input  logic [LANES-1:0][TAG_WIDTH-1:0]      req_tag_in,
    output logic [LANES-1:0]                     req_ready_in,
    output logic                                 rsp_valid_out,
    output logic [LANES-1:0]                     rsp_tmask_out,
    output logic [LANES-1:0][DATA_WIDTH-1:0]     rsp_data_out,
    output logic [TAG_WIDTH-1:0]                 rsp_tag_out,
    input  logic                                 rsp_ready_out
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned OUT_W = $clog2(RSP_QUEUE + 1);
    localparam int unsigned PTR_W = (RSP_QUEUE > 1) ? $clog2(RSP_QUEUE) : 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_QUEUE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic                              ready_q;
    logic [OUT_W-1:0]                  outstanding;
    logic [OUT_W-1:0]                  out_n;
    logic                              fire;
    logic                              has_rsp;
    logic                              push;
    logic                              pop;
    logic                              tag_err;
    logic [LANES-1:0]                  tmask;
    logic [TAG_WIDTH-1:0]              batch_tag;
    logic [LANES-1:0][DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH-1:0]             mem [NUM_WORDS];
    logic                              unused_addr;

    // Only the low index bits address the store.
    assign unused_addr = ^req_addr_in;

    assign req_ready_in = {LANES{ready_q}};
    assign fire         = ready_q & (|req_valid_in);
    assign tmask        = req_valid_in & ~req_rw_in;
    assign has_rsp      = |tmask;

    // Batch tag from lowest valid lane; read data sampled before this cycle's writes.
    always_comb begin
        batch_tag = '0;
        tag_err   = 1'b0;
        rd_data   = '0;
        for (int j = int'(LANES) - 1; j >= 0; j--) begin
            if (req_valid_in[j]) batch_tag = req_tag_in[j];
        end
        for (int j = 0; j < int'(LANES); j++) begin
            if (req_valid_in[j] && (req_tag_in[j] != batch_tag)) tag_err = 1'b1;
            if (tmask[j]) rd_data[j] = mem[req_addr_in[j][IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(fire && tag_err))
                else $error("vx_lane_responder: differing tags across valid lanes");
        end
    end

    // Store writes; later (higher) lanes override earlier ones on the same byte.
    always_ff @(posedge clk) begin
        if (fire) begin
            for (int j = 0; j < int'(LANES); j++) begin
                if (req_valid_in[j] && req_rw_in[j]) begin
                    for (int b = 0; b < int'(DATA_SIZE); b++) begin
                        if (req_byteen_in[j][b])
                            mem[req_addr_in[j][IDX_W-1:0]][b*8 +: 8] <= req_data_in[j][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Credit counter: in-flight read batches plus queue occupancy.
    assign out_n = outstanding + OUT_W'(fire & has_rsp) - OUT_W'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            ready_q     <= 1'b0;
        end else begin
            outstanding <= out_n;
            ready_q     <= (out_n < OUT_W'(RSP_QUEUE));
        end
    end

    // Fixed-latency response pipeline.
    logic [LATENCY-1:0]               p_valid;
    logic [LANES-1:0]                 p_tmask [LATENCY];
    logic [LANES-1:0][DATA_WIDTH-1:0] p_data  [LATENCY];
    logic [TAG_WIDTH-1:0]             p_tag   [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_valid <= '0;
            for (int k = 0; k < int'(LATENCY); k++) begin
                p_tmask[k] <= '0;
                p_data[k]  <= '0;
                p_tag[k]   <= '0;
            end
        end else begin
            p_valid[0] <= fire & has_rsp;
            p_tmask[0] <= tmask;
            p_data[0]  <= rd_data;
            p_tag[0]   <= batch_tag;
            for (int k = 1; k < int'(LATENCY); k++) begin
                p_valid[k] <= p_valid[k-1];
                p_tmask[k] <= p_tmask[k-1];
                p_data[k]  <= p_data[k-1];
                p_tag[k]   <= p_tag[k-1];
            end
        end
    end

    // Response queue with the head held in the output registers.
    logic [LANES-1:0]                 q_tmask [RSP_QUEUE];
    logic [LANES-1:0][DATA_WIDTH-1:0] q_data  [RSP_QUEUE];
    logic [TAG_WIDTH-1:0]             q_tag   [RSP_QUEUE];
    logic [PTR_W-1:0]                 wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [OUT_W-1:0]                 q_count, q_count_n, q_left;
    logic                             head_valid_n;
    logic [LANES-1:0]                 head_tmask_n;
    logic [LANES-1:0][DATA_WIDTH-1:0] head_data_n;
    logic [TAG_WIDTH-1:0]             head_tag_n;

    assign push = p_valid[LATENCY-1];
    assign pop  = rsp_valid_out & rsp_ready_out;

    always_ff @(posedge clk) begin
        if (push) begin
            q_tmask[wr_ptr] <= p_tmask[LATENCY-1];
            q_data[wr_ptr]  <= p_data[LATENCY-1];
            q_tag[wr_ptr]   <= p_tag[LATENCY-1];
        end
    end

    // Next head: oldest surviving entry, else the entry being pushed (bypass).
    always_comb begin
        wr_ptr_n     = push ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_n     = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        q_count_n    = q_count + OUT_W'(push) - OUT_W'(pop);
        q_left       = q_count - OUT_W'(pop);
        head_valid_n = 1'b0;
        head_tmask_n = '0;
        head_data_n  = '0;
        head_tag_n   = '0;
        if (q_left != '0) begin
            head_valid_n = 1'b1;
            head_tmask_n = q_tmask[rd_ptr_n];
            head_data_n  = q_data[rd_ptr_n];
            head_tag_n   = q_tag[rd_ptr_n];
        end else if (push) begin
            head_valid_n = 1'b1;
            head_tmask_n = p_tmask[LATENCY-1];
            head_data_n  = p_data[LATENCY-1];
            head_tag_n   = p_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            q_count       <= '0;
            rsp_valid_out <= 1'b0;
            rsp_tmask_out <= '0;
            rsp_data_out  <= '0;
            rsp_tag_out   <= '0;
        end else begin
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            q_count       <= q_count_n;
            rsp_valid_out <= head_valid_n;
            rsp_tmask_out <= head_tmask_n;
            rsp_data_out  <= head_data_n;
            rsp_tag_out   <= head_tag_n;
        end
    end

endmodule

// File: tb/tb_vx_lane_responder.sv
// Testbench for vx_lane_responder: vector table plus corner-case sequences,
// with a response scoreboard fed at accept time and drained by a monitor.
module tb_vx_lane_responder;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 30;
    localparam int unsigned TW    = 8;
    localparam int unsigned NV    = 11;

    typedef struct {
        logic [LANES-1:0]         valid;
        logic [LANES-1:0]         rw;
        logic [LANES-1:0][3:0]    byteen;
        logic [LANES-1:0][AW-1:0] addr;
        logic [LANES-1:0][DW-1:0] data;
        logic [TW-1:0]            tag;
        logic [LANES-1:0]         exp_tmask;
        logic [LANES-1:0][DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [LANES-1:0]         tmask;
        logic [LANES-1:0][DW-1:0] data;
        logic [TW-1:0]            tag;
    } rsp_t;

    logic                        clk;
    logic                        reset;
    logic [LANES-1:0]            req_valid;
    logic [LANES-1:0]            req_rw;
    logic [LANES-1:0][3:0]       req_byteen;
    logic [LANES-1:0][AW-1:0]    req_addr;
    logic [LANES-1:0][DW-1:0]    req_data;
    logic [LANES-1:0][TW-1:0]    req_tag;
    logic [LANES-1:0]            req_ready;
    logic                        rsp_valid;
    logic [LANES-1:0]            rsp_tmask;
    logic [LANES-1:0][DW-1:0]    rsp_data;
    logic [TW-1:0]               rsp_tag;
    logic                        rsp_ready;

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;
    vec_t vecs[NV];
    vec_t vw, vr;
    int   acc;

    vx_lane_responder #(
        .LANES(4), .DATA_SIZE(4), .TAG_WIDTH(8),
        .NUM_WORDS(64), .LATENCY(2), .RSP_QUEUE(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid), .req_rw_in(req_rw), .req_byteen_in(req_byteen),
        .req_addr_in(req_addr), .req_data_in(req_data), .req_tag_in(req_tag),
        .req_ready_in(req_ready),
        .rsp_valid_out(rsp_valid), .rsp_tmask_out(rsp_tmask), .rsp_data_out(rsp_data),
        .rsp_tag_out(rsp_tag), .rsp_ready_out(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid  = '0;
        req_rw     = '0;
        req_byteen = '0;
        req_addr   = '0;
        req_data   = '0;
        req_tag    = '0;
    endtask

    // Drive one batch, hold until accepted, queue its expected response.
    task automatic issue(input vec_t v);
        int waited = 0;
        req_valid  = v.valid;
        req_rw     = v.rw;
        req_byteen = v.byteen;
        req_addr   = v.addr;
        req_data   = v.data;
        req_tag    = {4{v.tag}};
        while (req_ready != 4'hF && waited < 50) begin
            step();
            waited++;
        end
        if (req_ready != 4'hF) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: ready %h after %0d cycles, required f", req_ready, waited);
        end else begin
            if (v.exp_tmask != '0) exp_q.push_back('{v.exp_tmask, v.exp_data, v.tag});
            step();
        end
        clear_req();
    endtask

    // One lane-0 read of address 5 per cycle for n cycles; counts accepts.
    task automatic try_reads(input int n, input logic [7:0] tag_base, output int accepted);
        accepted = 0;
        for (int k = 0; k < n; k++) begin
            clear_req();
            req_valid = 4'b0001;
            req_addr[0] = 30'd5;
            req_tag = {4{tag_base + 8'(k)}};
            if (req_ready == 4'hF) begin
                exp_q.push_back('{4'b0001, 128'hDEADBEEF, tag_base + 8'(k)});
                accepted++;
            end
            step();
        end
        clear_req();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: %0d responses pending, required 0", name, exp_q.size());
        end
    endtask

    // Scoreboard monitor: compare each handshaken response with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got tag %h, required no response", rsp_tag);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_tmask", 128'(rsp_tmask), 128'(mon_e.tmask));
                check("rsp_data", 128'(rsp_data), 128'(mon_e.data));
                check("rsp_tag", 128'(rsp_tag), 128'(mon_e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lane order in concatenations: {lane3, lane2, lane1, lane0}.
        vecs[0]  = '{4'hF, 4'hF, 16'hFFFF, {30'd13, 30'd12, 30'd11, 30'd10},
                     {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 8'h20, 4'h0, '0};
        vecs[1]  = '{4'hF, 4'h0, 16'h0000, {30'd10, 30'd11, 30'd12, 30'd13}, '0, 8'h21, 4'hF,
                     {32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3}};
        vecs[2]  = '{4'h3, 4'h1, 16'h0005, {30'd0, 30'd0, 30'd11, 30'd10},
                     {32'h0, 32'h0, 32'h0, 32'h12345678}, 8'h22, 4'h2,
                     {32'h0, 32'h0, 32'hA1A1A1A1, 32'h0}};
        vecs[3]  = '{4'h9, 4'h0, 16'h0000, {30'h1000000A, 30'd11, 30'd11, 30'd76}, '0, 8'h23, 4'h9,
                     {32'hA034A078, 32'h0, 32'h0, 32'hA2A2A2A2}};
        vecs[4]  = '{4'h4, 4'h1, 16'h000F, {30'd0, 30'd13, 30'd0, 30'd13},
                     {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 8'h24, 4'h4,
                     {32'h0, 32'hA3A3A3A3, 32'h0, 32'h0}};
        vecs[5]  = '{4'h1, 4'h0, 16'h0000, {30'd0, 30'd0, 30'd0, 30'd13}, '0, 8'h25, 4'h1,
                     {32'h0, 32'h0, 32'h0, 32'hA3A3A3A3}};
        vecs[6]  = '{4'hB, 4'hB, 16'h303F, {30'd2, 30'd0, 30'd2, 30'd2},
                     {32'h0000BBBB, 32'h0, 32'h0000AAAA, 32'h0}, 8'h26, 4'h0, '0};
        vecs[7]  = '{4'h2, 4'h0, 16'h0000, {30'd0, 30'd0, 30'd2, 30'd0}, '0, 8'h27, 4'h2,
                     {32'h0, 32'h0, 32'h0000BBBB, 32'h0}};
        vecs[8]  = '{4'h4, 4'h4, 16'h0F00, {30'd0, 30'd7, 30'd0, 30'd0},
                     {32'h0, 32'h77777777, 32'h0, 32'h0}, 8'h28, 4'h0, '0};
        vecs[9]  = '{4'h3, 4'h2, 16'h00F0, {30'd0, 30'd0, 30'd7, 30'd7},
                     {32'h0, 32'h0, 32'h11111111, 32'h0}, 8'h29, 4'h1,
                     {32'h0, 32'h0, 32'h0, 32'h77777777}};
        vecs[10] = '{4'h8, 4'h0, 16'h0000, {30'd7, 30'd0, 30'd0, 30'd0}, '0, 8'h2A, 4'h8,
                     {32'h11111111, 32'h0, 32'h0, 32'h0}};

        reset = 1'b1;
        rsp_ready = 1'b1;
        clear_req();
        step();
        step();
        check("reset_ready", 128'(req_ready), 128'h0);
        check("reset_rsp_valid", 128'(rsp_valid), 128'h0);
        check("reset_rsp_tmask", 128'(rsp_tmask), 128'h0);
        check("reset_rsp_data", 128'(rsp_data), 128'h0);
        check("reset_rsp_tag", 128'(rsp_tag), 128'h0);
        reset = 1'b0;
        step();
        check("ready_after_reset", 128'(req_ready), 128'hF);

        for (int i = 0; i < int'(NV); i++) issue(vecs[i]);
        wait_drain("table");

        // Write then read next cycle; response appears exactly two cycles after accept.
        vw = '{4'h1, 4'h1, 16'h000F, {30'd0, 30'd0, 30'd0, 30'd5},
               {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 8'h3B, 4'h0, '0};
        vr = '{4'h4, 4'h0, 16'h0000, {30'd0, 30'd5, 30'd0, 30'd0}, '0, 8'h3C, 4'h4,
               {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
        issue(vw);
        issue(vr);
        check("latency_cycle0", 128'(rsp_valid), 128'h0);
        step();
        check("latency_cycle1", 128'(rsp_valid), 128'h0);
        step();
        check("latency_cycle2", 128'(rsp_valid), 128'h1);
        wait_drain("latency");

        // Credit exhaustion with a stalled consumer, then in-order drain.
        rsp_ready = 1'b0;
        try_reads(6, 8'h40, acc);
        check("credit_accept_count", 128'(acc), 128'd4);
        check("credit_ready_low", 128'(req_ready), 128'h0);
        step();
        step();
        check("stall_valid", 128'(rsp_valid), 128'h1);
        check("stall_tag", 128'(rsp_tag), 128'h40);
        step();
        step();
        step();
        check("stall_hold_tag", 128'(rsp_tag), 128'h40);
        check("stall_hold_data", 128'(rsp_data), 128'hDEADBEEF);
        rsp_ready = 1'b1;
        wait_drain("credit");
        step();
        check("credit_ready_back", 128'(req_ready), 128'hF);

        // Write-only batches: blocked when full, free of credit when accepted.
        vw = '{4'h1, 4'h1, 16'h000F, {30'd0, 30'd0, 30'd0, 30'd20},
               {32'h0, 32'h0, 32'h0, 32'h20202020}, 8'h4E, 4'h0, '0};
        issue(vw);
        rsp_ready = 1'b0;
        try_reads(4, 8'h48, acc);
        check("wo_fill_count", 128'(acc), 128'd4);
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'h1;
            req_rw = 4'h1;
            req_byteen[0] = 4'hF;
            req_addr[0] = 30'd20;
            req_data[0] = 32'hFFFFFFFF;
            req_tag = {4{8'h4F}};
            check("wo_blocked_ready", 128'(req_ready), 128'h0);
            step();
        end
        clear_req();
        rsp_ready = 1'b1;
        wait_drain("wo_full");
        step();
        vw = '{4'h1, 4'h1, 16'h000F, {30'd0, 30'd0, 30'd0, 30'd21},
               {32'h0, 32'h0, 32'h0, 32'h21212121}, 8'h4D, 4'h0, '0};
        issue(vw);
        repeat (4) step();
        check("wo_no_rsp", 128'(rsp_valid), 128'h0);
        check("wo_ready_kept", 128'(req_ready), 128'hF);
        vr = '{4'h3, 4'h0, 16'h0000, {30'd0, 30'd0, 30'd21, 30'd20}, '0, 8'h50, 4'h3,
               {32'h0, 32'h0, 32'h21212121, 32'h20202020}};
        issue(vr);
        wait_drain("wo_read");

        // Reset with two queued and two in flight discards everything.
        rsp_ready = 1'b0;
        try_reads(2, 8'h60, acc);
        step();
        step();
        step();
        try_reads(2, 8'h62, acc);
        check("pre_reset_valid", 128'(rsp_valid), 128'h1);
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 128'(rsp_valid), 128'h0);
        check("midrst_rsp_tmask", 128'(rsp_tmask), 128'h0);
        check("midrst_ready", 128'(req_ready), 128'h0);
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) step();
        check("postrst_ready", 128'(req_ready), 128'hF);
        check("postrst_no_rsp", 128'(rsp_valid), 128'h0);
        rsp_ready = 1'b0;
        try_reads(6, 8'h70, acc);
        check("postrst_credits", 128'(acc), 128'd4);
        rsp_ready = 1'b1;
        wait_drain("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
